ahb_resp_mux: RTL and testbench
===============================

AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave response channels (legal range 2..16).
REQ-002 SHALL have parameter DATA_W, default 32, read-data width in bits (32 or 64).
REQ-003 SHALL have parameter ERRCNT_W, default 16, width of the decode-error counter.
REQ-004 SHALL have port hclk  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port hreset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port hsel  input  NUM_SLAVES  address-phase slave selects from the decoder, expected one-hot.
REQ-007 SHALL have port htrans  input  2  address-phase transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-008 SHALL have port hrdata_s  input  NUM_SLAVES*DATA_W  flattened slave read data, slave i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port hreadyout_s  input  NUM_SLAVES  per-slave ready.
REQ-010 SHALL have port hresp_s  input  NUM_SLAVES  per-slave response (0 OKAY, 1 ERROR).
REQ-011 SHALL have port hrdata  output  DATA_W  muxed read data to the master.
REQ-012 SHALL have port hready  output  1  muxed ready, also used internally as the bus-wide HREADY.
REQ-013 SHALL have port hresp  output  1  muxed response.
REQ-014 SHALL have port err_cnt  output  ERRCNT_W  count of decode-error responses issued.

Function
REQ-015 SHALL register the data-phase select sel_q (NUM_SLAVES bits) from hsel only on a rising edge where hready=1; sel_q SHALL hold while hready=0.
REQ-016 SHALL classify each accepted address phase: exactly one hsel bit set -> SLAVE; htrans in {NONSEQ, SEQ} with zero or multiple hsel bits set -> DECERR; otherwise -> IDLE.
REQ-017 In a SLAVE data phase, the block SHALL drive hrdata, hready and hresp from the channel selected by sel_q, combinationally and with zero added latency.
REQ-018 In an IDLE data phase, the block SHALL drive hready=1, hresp=0 and hrdata=0 (zero-wait OKAY).
REQ-019 A DECERR data phase SHALL be served by an internal default slave with FSM states DS_IDLE, DS_ERR1 and DS_ERR2.
REQ-020 The default-slave FSM SHALL make these transitions: DS_IDLE->DS_ERR1 on acceptance of a DECERR phase; DS_ERR1->DS_ERR2 unconditionally; DS_ERR2->DS_ERR1 if a new DECERR phase is accepted in that cycle, else ->DS_IDLE.
REQ-021 In DS_ERR1 the block SHALL drive hready=0, hresp=1 and hrdata=0.
REQ-022 In DS_ERR2 the block SHALL drive hready=1, hresp=1 and hrdata=0, giving a two-cycle ERROR response.
REQ-023 While the FSM is in DS_ERR1, slave outputs SHALL be ignored and sel_q SHALL be held.
REQ-024 A DECERR phase SHALL never forward a slave's hreadyout, even if multiple hsel bits were set.
REQ-025 err_cnt SHALL increment by 1 on each entry to DS_ERR1 and saturate at all-ones, with no wrap-around.
REQ-026 Back-to-back transfers SHALL be pipelined: the address phase accepted while the current data phase completes (hready=1) SHALL take effect in the next cycle with no bubble.
REQ-027 A slave wait state (selected hreadyout_s=0) SHALL propagate to hready in the same cycle and stall acceptance of the next address phase.

Reset
REQ-028 While hreset=1 at a clock edge, the block SHALL set sel_q=0, FSM=DS_IDLE and err_cnt=0.
REQ-029 After reset, the outputs SHALL read hready=1, hresp=0 and hrdata=0 (IDLE data phase).
REQ-030 A reset asserted mid-error (DS_ERR1 or DS_ERR2) or mid-wait-state SHALL abandon the transfer and return the block to the REQ-028/REQ-029 values on the next edge.

Structure
REQ-031 A shared package ahb_pkg SHALL hold the HTRANS and HRESP encodings, the default-slave state encoding and the data-phase class encoding (IDLE/SLAVE/DECERR).
REQ-032 The default slave (the FSM plus err_cnt) SHALL be a sub-module named ahb_default_slave; the one-hot data-phase mux SHALL stay in ahb_resp_mux.

Verification
REQ-033 Reset, then htrans=IDLE with hsel=0 -> hready=1, hresp=0, hrdata=0 and err_cnt=0.
REQ-034 NONSEQ with hsel=4'b0100, hrdata_s slot2=32'hCAFE_0001 and hreadyout_s[2] low for 2 cycles -> hready=0 for 2 cycles, then hrdata=32'hCAFE_0001, hready=1 and hresp=0.
REQ-035 NONSEQ with hsel=0 -> next cycle hready=0/hresp=1, following cycle hready=1/hresp=1, and err_cnt=1.
REQ-036 Back-to-back NONSEQ to slave 0 then slave 3 -> data phases taken from channel 0 then channel 3 on consecutive cycles, with no idle cycle between them.
REQ-037 NONSEQ with hsel=4'b0011 -> two-cycle ERROR response, no slave hreadyout forwarded; and with err_cnt preset to all-ones, err_cnt stays at all-ones.
REQ-038 hreset asserted during DS_ERR1 -> next cycle hready=1, hresp=0 and err_cnt=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings for the response mux and its default slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'b00,
    PH_SLAVE  = 2'b01,
    PH_DECERR = 2'b10
  } phase_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers decode errors with a two-cycle ERROR response and
// counts how many it has issued (saturating).
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int ERRCNT_W = 16
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic                accept_decerr,
  output ds_state_e           state,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam logic [ERRCNT_W-1:0] CNT_ONE = {{(ERRCNT_W-1){1'b0}}, 1'b1};

  ds_state_e state_next;
  logic      enter_err1;

  always_comb begin
    state_next = state;
    case (state)
      DS_IDLE: if (accept_decerr) state_next = DS_ERR1;
      DS_ERR1: state_next = DS_ERR2;
      DS_ERR2: state_next = accept_decerr ? DS_ERR1 : DS_IDLE;
      default: state_next = DS_IDLE;
    endcase
    enter_err1 = (state_next == DS_ERR1) && (state != DS_ERR1);
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= DS_IDLE;
      err_cnt <= '0;
    end else begin
      state <= state_next;
      if (enter_err1 && (err_cnt != '1)) err_cnt <= err_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB slave-to-master response mux with a built-in default slave that
// answers unmapped or ambiguous address phases with ERROR.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int ERRCNT_W   = 16
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic [NUM_SLAVES-1:0]        hsel,
  input  logic [1:0]                   htrans,
  input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
  input  logic [NUM_SLAVES-1:0]        hreadyout_s,
  input  logic [NUM_SLAVES-1:0]        hresp_s,
  output logic [DATA_W-1:0]            hrdata,
  output logic                         hready,
  output logic                         hresp,
  output logic [ERRCNT_W-1:0]          err_cnt
);

  logic [NUM_SLAVES-1:0] sel_q;
  phase_e                phase_q;
  phase_e                addr_phase;
  logic [4:0]            sel_count;
  logic                  trans_active;
  logic                  accept_decerr;
  ds_state_e             ds_state;

  logic [DATA_W-1:0]     mux_data;
  logic                  mux_ready;
  logic                  mux_resp;

  // Classify the address phase currently on the bus.
  always_comb begin
    sel_count = 5'd0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (hsel[i]) sel_count = sel_count + 5'd1;
    end
    trans_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    addr_phase   = PH_IDLE;
    if (sel_count == 5'd1)  addr_phase = PH_SLAVE;
    else if (trans_active)  addr_phase = PH_DECERR;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      sel_q   <= '0;
      phase_q <= PH_IDLE;
    end else if (hready) begin
      sel_q   <= hsel;
      phase_q <= addr_phase;
    end
  end

  // AND-OR mux; sel_q is one-hot whenever phase_q is PH_SLAVE.
  always_comb begin
    mux_data  = '0;
    mux_ready = 1'b0;
    mux_resp  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        mux_data  = mux_data | hrdata_s[i*DATA_W +: DATA_W];
        mux_ready = mux_ready | hreadyout_s[i];
        mux_resp  = mux_resp | hresp_s[i];
      end
    end
  end

  // Default slave takes priority so a multi-select never leaks a slave's ready.
  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    if (ds_state != DS_IDLE) begin
      hready = (ds_state != DS_ERR1);
      hresp  = HRESP_ERROR;
    end else if (phase_q == PH_SLAVE) begin
      hrdata = mux_data;
      hready = mux_ready;
      hresp  = mux_resp;
    end
  end

  assign accept_decerr = hready && (addr_phase == PH_DECERR);

  ahb_default_slave #(
    .ERRCNT_W(ERRCNT_W)
  ) u_default_slave (
    .hclk         (hclk),
    .hreset       (hreset),
    .accept_decerr(accept_decerr),
    .state        (ds_state),
    .err_cnt      (err_cnt)
  );

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed bench for ahb_resp_mux: driver pushes the per-cycle expected
// response, a monitor pops and compares mid-cycle.
module tb_ahb_resp_mux;

  localparam int NS  = 4;
  localparam int DW  = 32;
  localparam int CW  = 3;
  localparam int EXW = 1 + 1 + DW + CW;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic              hclk = 1'b0;
  logic              hreset;
  logic [NS-1:0]     hsel;
  logic [1:0]        htrans;
  logic [NS*DW-1:0]  hrdata_s;
  logic [NS-1:0]     hreadyout_s;
  logic [NS-1:0]     hresp_s;
  logic [DW-1:0]     hrdata;
  logic              hready;
  logic              hresp;
  logic [CW-1:0]     err_cnt;

  logic [EXW-1:0] exp_q[$];
  string          name_q[$];
  int             n_checks = 0;
  int             n_pass   = 0;

  ahb_resp_mux #(
    .NUM_SLAVES(NS),
    .DATA_W    (DW),
    .ERRCNT_W  (CW)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .hsel       (hsel),
    .htrans     (htrans),
    .hrdata_s   (hrdata_s),
    .hreadyout_s(hreadyout_s),
    .hresp_s    (hresp_s),
    .hrdata     (hrdata),
    .hready     (hready),
    .hresp      (hresp),
    .err_cnt    (err_cnt)
  );

  // Clock / reset
  always #5 hclk = ~hclk;

  // Driver: apply one cycle of inputs and push the outputs expected in that cycle.
  task automatic step(input logic [NS-1:0] sel, input logic [1:0] trans,
                      input logic [NS-1:0] rdy, input logic [NS-1:0] rsp,
                      input logic rst, input logic e_ready, input logic e_resp,
                      input logic [DW-1:0] e_data, input logic [CW-1:0] e_cnt,
                      input string nm);
    @(negedge hclk);
    #1;
    hsel        = sel;
    htrans      = trans;
    hreadyout_s = rdy;
    hresp_s     = rsp;
    hreset      = rst;
    exp_q.push_back({e_ready, e_resp, e_data, e_cnt});
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [EXW-1:0] exp_v;
    logic [EXW-1:0] act_v;
    string          nm;
    forever begin
      @(negedge hclk);
      #2;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = {hready, hresp, hrdata, err_cnt};
        n_checks++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL %s: got ready=%b resp=%b data=%h cnt=%0d, want ready=%b resp=%b data=%h cnt=%0d",
                      nm, act_v[EXW-1], act_v[EXW-2], act_v[CW +: DW], act_v[CW-1:0],
                      exp_v[EXW-1], exp_v[EXW-2], exp_v[CW +: DW], exp_v[CW-1:0]);
      end
    end
  end

  initial begin
    hreset      = 1'b1;
    hsel        = '0;
    htrans      = T_IDLE;
    hreadyout_s = '1;
    hresp_s     = '0;
    hrdata_s    = {32'h3333_0003, 32'hCAFE_0001, 32'h2222_0000, 32'h1111_0000};
    repeat (2) @(negedge hclk);
    #1 hreset = 1'b0;

    step(4'b0000, T_IDLE,   4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, "reset_idle");
    // Slave 2 with two wait states; next transfer to slave 0 must stall.
    step(4'b0100, T_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, "addr_s2");
    step(4'b0001, T_NONSEQ, 4'b1011, 4'b0000, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, 3'd0, "s2_wait1");
    step(4'b0001, T_NONSEQ, 4'b1011, 4'b0000, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, 3'd0, "s2_wait2");
    step(4'b0001, T_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 32'hCAFE_0001, 3'd0, "s2_done");
    // Back-to-back slave 0 then slave 3, then a no-select decode error.
    step(4'b1000, T_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h1111_0000, 3'd0, "b2b_s0");
    step(4'b0000, T_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h3333_0003, 3'd0, "b2b_s3");
    // ERR1 ignores slave 0 signals and holds the pending address phase.
    step(4'b0001, T_NONSEQ, 4'b1110, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h0, 3'd1, "decerr_err1");
    step(4'b0011, T_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 32'h0, 3'd1, "decerr_err2");
    step(4'b0000, T_IDLE,   4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h0, 3'd2, "multi_err1");
    step(4'b0000, T_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 32'h0, 3'd2, "multi_err2");
    // Chain of decode errors driving the counter into saturation.
    for (int k = 3; k <= 9; k++) begin
      step(4'b0000, T_IDLE, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h0,
           (k > 7) ? 3'd7 : 3'(k), "sat_err1");
      if (k < 9)
        step(4'b0000, (k % 2 == 0) ? T_SEQ : T_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1,
             32'h0, (k > 7) ? 3'd7 : 3'(k), "sat_err2");
      else
        step(4'b0010, T_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 32'h0, 3'd7, "sat_err2_last");
    end
    // Slave 1 forwards its ERROR response; then reset in the middle of ERR1.
    step(4'b0000, T_NONSEQ, 4'b1111, 4'b0010, 1'b0, 1'b1, 1'b1, 32'h2222_0000, 3'd7, "s1_resp");
    step(4'b0000, T_IDLE,   4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 32'h0, 3'd7, "rst_in_err1");
    step(4'b0000, T_IDLE,   4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, "after_rst_err");
    // BUSY with no select is an IDLE phase.
    step(4'b0000, T_BUSY,   4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, "busy_addr");
    step(4'b0100, T_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, "busy_data");
    // Reset during a slave wait state.
    step(4'b0000, T_IDLE,   4'b1011, 4'b0000, 1'b1, 1'b0, 1'b0, 32'hCAFE_0001, 3'd0, "rst_in_wait");
    step(4'b0000, T_IDLE,   4'b1011, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, "after_rst_wait");

    repeat (3) @(negedge hclk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
